// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
// Bundles the two handshakes around the read-side drain engine:
//   FIFO side   : rempty / rdata (from the FIFO), rinc (pop strobe to the FIFO)
//   Stream side : m_valid / m_data (to downstream), m_ready (from downstream)
// Modports:
//   master - the drain engine (drives rinc, m_valid, m_data)
//   slave  - the environment around it (FIFO plus downstream sink)
// Parameter DSIZE is the data width and must match the FIFO's DSIZE.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-domain drain engine for the async FIFO. Words are popped from the FIFO
// into a 2-entry skid buffer (head drives m_data, skid holds the overflow
// word) and presented downstream on a valid/ready stream. Because the pop
// strobe only looks at registered occupancy, rinc has no combinational path
// from m_ready, yet the two entries still sustain one beat per cycle.
// Ports:
//   rclk     - read-domain clock, rising edge
//   rrst_n   - asynchronous active-low reset
//   flush    - synchronous discard of all buffered words
//   bus      - fifo_rd_stream_if.master (rempty, rdata, rinc,
//              m_valid, m_data, m_ready)
//   rd_count - saturating accepted-beat counter, CWIDTH bits
//              (exists only when FIFO_RD_STATS_EN is defined)
// Optional feature macro: FIFO_RD_STATS_EN
module fifo_rd_stream #(
  parameter int DSIZE  = 8,
  parameter int CWIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 flush,
`ifdef FIFO_RD_STATS_EN
  output logic [CWIDTH-1:0]    rd_count,
`endif
  fifo_rd_stream_if.master     bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             occ;
  occ_t             occ_nxt;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] skid;
  logic             rinc_i;
  logic             valid_i;
  logic             push;
  logic             pop;

  // Occupancy register. Reset empties the buffer immediately, which is safe
  // because the FIFO pointers are reset in this same domain.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ <= EMPTY;
    end else begin
      occ <= occ_nxt;
    end
  end

  // Next occupancy. Flush wins over everything; rinc is already forced low
  // during a flush, so no word is taken from the FIFO that would be lost.
  always_comb begin
    occ_nxt = occ;
    if (flush) begin
      occ_nxt = EMPTY;
    end else begin
      case (occ)
        EMPTY: if (push) occ_nxt = ONE;
        ONE: begin
          if (push && !pop) begin
            occ_nxt = TWO;
          end else if (!push && pop) begin
            occ_nxt = EMPTY;
          end
        end
        TWO:     if (pop) occ_nxt = ONE;
        default: occ_nxt = EMPTY;
      endcase
    end
  end

  // Output decode. rinc only looks at rempty, flush, reset and registered
  // occupancy, never at m_ready, which keeps the FIFO pop path short.
  always_comb begin
    rinc_i  = rrst_n && !bus.rempty && !flush && (occ != TWO);
    valid_i = (occ != EMPTY);
    push    = rinc_i;
    pop     = valid_i && bus.m_ready;
  end

  assign bus.rinc    = rinc_i;
  assign bus.m_valid = valid_i;
  assign bus.m_data  = head;

  // Data path. A popped word goes straight to head when head is free or is
  // leaving this cycle; otherwise it parks in skid and moves up on the next
  // accepted beat. Head stays untouched while stalled, so m_data is stable.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      case (occ)
        EMPTY: if (push) head <= bus.rdata;
        ONE: begin
          if (push && pop) begin
            head <= bus.rdata;
          end else if (push) begin
            skid <= bus.rdata;
          end
        end
        TWO:     if (pop) head <= skid;
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  // Accepted-beat counter. It saturates rather than wraps and survives a
  // flush; a beat taken in the flush cycle still counts.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count <= '0;
    end else if (pop && (rd_count != {CWIDTH{1'b1}})) begin
      rd_count <= rd_count + CWIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Self-checking bench for fifo_rd_stream. A queue stands in for the FIFO and
// a second queue holds the words the engine has taken but not yet delivered;
// every cycle the stream outputs and rinc are compared against that model.
// The counter is built with a 4-bit width so saturation is reachable.
// Optional feature macro: FIFO_RD_STATS_EN
module tb_fifo_rd_stream;

  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic rclk = 1'b0;
  logic rrst_n;
  logic flush;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] rd_count;
`endif

  fifo_rd_stream_if #(.DSIZE(DW)) bus ();

  fifo_rd_stream #(
    .DSIZE  (DW),
    .CWIDTH (CW)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .flush    (flush),
`ifdef FIFO_RD_STATS_EN
    .rd_count (rd_count),
`endif
    .bus      (bus)
  );

  always #5 rclk = ~rclk;

  // Model state: FIFO contents, words held by the engine, delivered words.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] inflight[$];
  logic [DW-1:0] got[$];
  int            got_cyc[$];

  bit            obs_rinc, exp_rinc, obs_valid, exp_valid, beat;
  logic [DW-1:0] obs_data, exp_data;
  int            exp_count;
  int            cycle_no;
  int            n_vec;
  int            n_err;

  // One read-clock cycle, entered and left at a falling edge. Inputs are
  // driven, outputs sampled mid-cycle, then the model advances at the edge.
  task automatic tick(input bit rdy, input bit fl);
    flush       = fl;
    bus.m_ready = rdy;
    if (fq.size() != 0) begin
      bus.rempty = 1'b0;
      bus.rdata  = fq[0];
    end else begin
      bus.rempty = 1'b1;
      bus.rdata  = DW'($urandom);
    end
    #1;
    obs_rinc  = bus.rinc;
    obs_valid = bus.m_valid;
    obs_data  = bus.m_data;
    exp_rinc  = (fq.size() != 0) && !fl && (inflight.size() < 2);
    exp_valid = (inflight.size() != 0);
    exp_data  = exp_valid ? inflight[0] : '0;
    beat      = exp_valid && rdy;
    @(posedge rclk);
    if (beat) begin
      void'(inflight.pop_front());
      got.push_back(obs_data);
      got_cyc.push_back(cycle_no);
      if (exp_count < CMAX) exp_count++;
    end
    if (obs_rinc && fq.size() != 0) inflight.push_back(fq.pop_front());
    if (fl) inflight.delete();
    cycle_no++;
    @(negedge rclk);
  endtask

  task automatic test_reset;
    rrst_n      = 1'b0;
    flush       = 1'b0;
    bus.m_ready = 1'b0;
    bus.rempty  = 1'b0;
    bus.rdata   = 8'h77;
    #2;
    n_vec++;
    if (bus.rinc !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_rinc got=%b exp=0", bus.rinc);
    end
    n_vec++;
    if (bus.m_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.m_valid);
    end
    n_vec++;
    if (bus.m_data !== 8'h00) begin
      n_err++; $display("[TB] FAIL reset_data got=%h exp=00", bus.m_data);
    end
`ifdef FIFO_RD_STATS_EN
    n_vec++;
    if (rd_count !== '0) begin
      n_err++; $display("[TB] FAIL reset_count got=%0d exp=0", rd_count);
    end
`endif
    bus.rempty = 1'b1;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_streaming;
    int start;
    got.delete(); got_cyc.delete();
    for (int i = 1; i <= 16; i++) fq.push_back(DW'(i));
    start = cycle_no;
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (obs_rinc !== exp_rinc) begin
        n_err++; $display("[TB] FAIL stream_rinc cyc=%0d got=%b exp=%b", c, obs_rinc, exp_rinc);
      end
      n_vec++;
      if (obs_valid !== exp_valid) begin
        n_err++; $display("[TB] FAIL stream_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid);
      end
      if (exp_valid) begin
        n_vec++;
        if (obs_data !== exp_data) begin
          n_err++; $display("[TB] FAIL stream_data cyc=%0d got=%h exp=%h", c, obs_data, exp_data);
        end
      end
    end
    n_vec++;
    if (got.size() != 16) begin
      n_err++; $display("[TB] FAIL stream_beats got=%0d exp=16", got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_vec++;
        if (got[i] !== DW'(i + 1)) begin
          n_err++; $display("[TB] FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], DW'(i + 1));
        end
      end
      n_vec++;
      if (got_cyc[0] != start + 1) begin
        n_err++; $display("[TB] FAIL stream_latency got=%0d exp=%0d", got_cyc[0] - start, 1);
      end
      n_vec++;
      if (got_cyc[15] - got_cyc[0] != 15) begin
        n_err++; $display("[TB] FAIL stream_gapless span got=%0d exp=15", got_cyc[15] - got_cyc[0]);
      end
    end
`ifdef FIFO_RD_STATS_EN
    n_vec++;
    if (rd_count !== CW'(exp_count)) begin
      n_err++; $display("[TB] FAIL stream_count got=%0d exp=%0d", rd_count, exp_count);
    end
`endif
  endtask

  task automatic test_backpressure;
    int pulses;
    logic [DW-1:0] want [4];
    want[0] = 8'hA0; want[1] = 8'hA1; want[2] = 8'hA2; want[3] = 8'hA3;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 4; i++) fq.push_back(want[i]);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0);
      if (obs_rinc) pulses++;
      n_vec++;
      if (obs_rinc !== exp_rinc) begin
        n_err++; $display("[TB] FAIL bp_rinc cyc=%0d got=%b exp=%b", c, obs_rinc, exp_rinc);
      end
      if (c > 0) begin
        n_vec++;
        if (obs_valid !== 1'b1 || obs_data !== 8'hA0) begin
          n_err++; $display("[TB] FAIL bp_stall cyc=%0d got=%b/%h exp=1/a0", c, obs_valid, obs_data);
        end
      end
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++; $display("[TB] FAIL bp_pulses got=%0d exp=2", pulses);
    end
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (obs_rinc !== exp_rinc) begin
        n_err++; $display("[TB] FAIL bp_drain_rinc cyc=%0d got=%b exp=%b", c, obs_rinc, exp_rinc);
      end
      n_vec++;
      if (obs_valid !== exp_valid) begin
        n_err++; $display("[TB] FAIL bp_drain_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid);
      end
    end
    n_vec++;
    if (got.size() != 4) begin
      n_err++; $display("[TB] FAIL bp_beats got=%0d exp=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got[i] !== want[i]) begin
          n_err++; $display("[TB] FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_empty_boundary;
    int pulses;
    got.delete(); got_cyc.delete();
    fq.push_back(8'h5A);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 1'b0);
      if (obs_rinc) pulses++;
      n_vec++;
      if (obs_rinc !== exp_rinc) begin
        n_err++; $display("[TB] FAIL empty_rinc cyc=%0d got=%b exp=%b", c, obs_rinc, exp_rinc);
      end
      n_vec++;
      if (obs_valid !== exp_valid) begin
        n_err++; $display("[TB] FAIL empty_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid);
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("[TB] FAIL empty_pulses got=%0d exp=1", pulses);
    end
    n_vec++;
    if (got.size() != 1 || got[0] !== 8'h5A) begin
      n_err++; $display("[TB] FAIL empty_beat got=%0d beats first=%h exp=1 beat 5a", got.size(),
                        (got.size() != 0) ? got[0] : 8'h00);
    end
  endtask

  task automatic test_flush;
    got.delete(); got_cyc.delete();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_vec++;
    if (obs_rinc !== 1'b0) begin
      n_err++; $display("[TB] FAIL flush_rinc got=%b exp=0", obs_rinc);
    end
    n_vec++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h11) begin
      n_err++; $display("[TB] FAIL flush_pre got=%b/%h exp=1/11", obs_valid, obs_data);
    end
    tick(1'b0, 1'b0);
    n_vec++;
    if (obs_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL flush_valid got=%b exp=0", obs_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (obs_valid !== exp_valid) begin
        n_err++; $display("[TB] FAIL flush_after_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid);
      end
    end
    n_vec++;
    if (got.size() != 1 || got[0] !== 8'h33) begin
      n_err++; $display("[TB] FAIL flush_next got=%0d beats first=%h exp=1 beat 33", got.size(),
                        (got.size() != 0) ? got[0] : 8'h00);
    end
`ifdef FIFO_RD_STATS_EN
    n_vec++;
    if (rd_count !== CW'(exp_count)) begin
      n_err++; $display("[TB] FAIL flush_count got=%0d exp=%0d", rd_count, exp_count);
    end
`endif
  endtask

  task automatic test_random;
    bit rdy, fl;
    for (int c = 0; c < 400; c++) begin
      if (fq.size() < 8 && $urandom_range(0, 9) < 5) fq.push_back(DW'($urandom));
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      tick(rdy, fl);
      n_vec++;
      if (obs_rinc !== exp_rinc) begin
        n_err++; $display("[TB] FAIL rand_rinc cyc=%0d got=%b exp=%b", c, obs_rinc, exp_rinc);
      end
      n_vec++;
      if (obs_valid !== exp_valid) begin
        n_err++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid);
      end
      if (exp_valid) begin
        n_vec++;
        if (obs_data !== exp_data) begin
          n_err++; $display("[TB] FAIL rand_data cyc=%0d got=%h exp=%h", c, obs_data, exp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    fq.delete();
    fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    bus.rempty  = 1'b0;
    bus.rdata   = fq[0];
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    #2;
    rrst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.rinc !== 1'b0) begin
      n_err++; $display("[TB] FAIL midreset got valid=%b data=%h rinc=%b exp 0/00/0",
                        bus.m_valid, bus.m_data, bus.rinc);
    end
    fq.delete();
    inflight.delete();
    exp_count = 0;
`ifdef FIFO_RD_STATS_EN
    n_vec++;
    if (rd_count !== '0) begin
      n_err++; $display("[TB] FAIL midreset_count got=%0d exp=0", rd_count);
    end
`endif
    bus.rempty = 1'b1;
    @(negedge rclk);
    rrst_n = 1'b1;
    tick(1'b1, 1'b0);
    n_vec++;
    if (obs_rinc !== 1'b0 || obs_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL midreset_idle got rinc=%b valid=%b exp 0/0", obs_rinc, obs_valid);
    end
    fq.push_back(8'h66);
    tick(1'b1, 1'b0);
    n_vec++;
    if (obs_rinc !== 1'b1) begin
      n_err++; $display("[TB] FAIL midreset_rinc got=%b exp=1", obs_rinc);
    end
    tick(1'b1, 1'b0);
    n_vec++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h66) begin
      n_err++; $display("[TB] FAIL midreset_first got=%b/%h exp=1/66", obs_valid, obs_data);
    end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_saturation;
    for (int i = 0; i < 20; i++) fq.push_back(DW'(8'h80 + i));
    for (int c = 0; c < 26; c++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (rd_count !== CW'(exp_count)) begin
        n_err++; $display("[TB] FAIL sat_count cyc=%0d got=%0d exp=%0d", c, rd_count, exp_count);
      end
    end
    n_vec++;
    if (rd_count !== CW'(CMAX)) begin
      n_err++; $display("[TB] FAIL sat_final got=%0d exp=%0d", rd_count, CMAX);
    end
  endtask
`endif

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_count = 0;
    cycle_no  = 0;
    $display("[TB] fifo_rd_stream bench start");
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_random();
    test_reset_mid();
`ifdef FIFO_RD_STATS_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
